// File: rtl/reg_stream_reader.sv
// reg_stream_reader
// Streams a contiguous, wrapping range of register-file entries out over a
// valid/ready handshake. The read index is driven from a register, and the
// register file answers combinationally on reg_out. This block only reads.
//
// State table:
//   IDLE | waiting for start; no beat held
//   RUN  | walking the range; out_* holds the current beat
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   start            request a read-out (sampled only in IDLE)
//   first_reg        first index to read (sampled with start)
//   count            number of registers to read, 0..2**D (sampled with start)
//   abort            cancel a read-out in progress, dropping any pending beat
//   reg_from_number  read index to the register file
//   reg_out          register-file read data for reg_from_number
//   out_data         streamed register value
//   out_index        index out_data came from
//   out_valid        out_data/out_index/out_last valid
//   out_ready        consumer accepts the beat when high with out_valid
//   out_last         final beat of the read-out
//   busy             high in RUN
//   done             one-cycle pulse on normal completion
module reg_stream_reader #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] first_reg,
  input  logic [D:0]   count,
  input  logic         abort,
  output logic [D-1:0] reg_from_number,
  input  logic [W-1:0] reg_out,
  output logic [W-1:0] out_data,
  output logic [D-1:0] out_index,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [D:0] REM_ZERO = '0;
  localparam logic [D:0] REM_ONE  = {{D{1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [D-1:0] addr;
  logic [D:0]   remaining;

  logic go;          // latch the range and enter RUN
  logic empty_done;  // start with count==0: complete without any beat
  logic load;        // capture reg_out into the output slot
  logic accept;      // consumer takes the current beat
  logic finish;      // last beat accepted
  logic kill;        // abort while running

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    go         = 1'b0;
    empty_done = 1'b0;
    load       = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    kill       = 1'b0;
    case (state)
      IDLE: begin
        // abort has priority over start while idle
        if (start && !abort) begin
          if (count != REM_ZERO) begin
            go        = 1'b1;
            state_nxt = RUN;
          end else begin
            empty_done = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          kill      = 1'b1;
          state_nxt = IDLE;
        end else begin
          accept = out_valid && out_ready;
          // the slot may be refilled in the same cycle its beat is taken
          load   = (remaining != REM_ZERO) && (!out_valid || out_ready);
          if (accept && (remaining == REM_ZERO) && out_last) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish || empty_done;
      if (go) begin
        addr      <= first_reg;
        remaining <= count;
      end
      if (kill) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        remaining <= '0;
      end else if (load) begin
        // reg_out reflects the contents before any write landing on this edge
        out_data  <= reg_out;
        out_index <= addr;
        out_valid <= 1'b1;
        out_last  <= (remaining == REM_ONE);
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign reg_from_number = addr;
  assign busy            = (state == RUN);

endmodule

// File: tb/tb_reg_stream_reader.sv
module tb_reg_stream_reader;

  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [D-1:0] first_reg = '0;
  logic [D:0]   count = '0;
  logic         abort = 1'b0;
  logic [D-1:0] reg_from_number;
  logic [W-1:0] reg_out;
  logic [W-1:0] out_data;
  logic [D-1:0] out_index;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         busy;
  logic         done;

  reg_stream_reader #(.W(W), .D(D)) dut (
    .clk(clk), .reset(reset), .start(start), .first_reg(first_reg),
    .count(count), .abort(abort), .reg_from_number(reg_from_number),
    .reg_out(reg_out), .out_data(out_data), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [W-1:0] rf [N];
  assign reg_out = rf[reg_from_number];

  typedef struct {
    logic [D-1:0] idx;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t q[$];
  beat_t mon_e;

  int total = 0;
  int passed = 0;
  int done_seen = 0;
  int acc_cnt = 0;
  logic exp_done = 1'b0;
  logic exp_done_n;
  logic model_run = 1'b0;
  int ready_mode = 0;   // 0: ready_val, 1: always 1, 2: random
  logic ready_val = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       out_ready = 1'b1;
      2:       out_ready = ($urandom % 4) != 0;
      default: out_ready = ready_val;
    endcase
  end

  // Monitor: pops the scoreboard on every accepted beat and tracks done timing.
  always @(negedge clk) begin
    if (reset) begin
      exp_done = 1'b0;
    end else begin
      check("done_timing", {31'd0, done}, {31'd0, exp_done});
      if (done) done_seen++;
      exp_done_n = 1'b0;
      if (out_valid && out_ready && !abort) begin
        if (q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          check("beat_index", {28'd0, out_index}, {28'd0, mon_e.idx});
          check("beat_data", {24'd0, out_data}, {24'd0, mon_e.data});
          check("beat_last", {31'd0, out_last}, {31'd0, mon_e.last});
          acc_cnt++;
          if (mon_e.last) exp_done_n = 1'b1;
        end
      end
      if (start && !abort && !model_run && count == 0) exp_done_n = 1'b1;
      exp_done = exp_done_n;
    end
  end

  task automatic run_start(input int first, input int cnt);
    @(posedge clk); #1;
    start = 1'b1;
    first_reg = first[D-1:0];
    count = cnt[D:0];
    for (int i = 0; i < cnt; i++) begin
      beat_t b;
      b.idx  = (first + i) % N;
      b.data = rf[(first + i) % N];
      b.last = (i == cnt - 1);
      q.push_back(b);
    end
    model_run = (cnt != 0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < bound);
    if (!done) check("done_timeout", 32'd0, 32'd1);
    model_run = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!out_valid && c < bound);
    if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc, d0, a0;
    for (int i = 0; i < N; i++) rf[i] = 8'h10 + i[7:0];

    // reset state
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_index", {28'd0, reg_from_number}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // basic run with latency and throughput
    ready_mode = 1;
    d0 = done_seen;
    run_start(3, 4);
    @(negedge clk);
    check("latch_busy", {31'd0, busy}, 32'd1);
    check("latch_no_valid", {31'd0, out_valid}, 32'd0);
    wait_done(50, cyc);
    check("basic_cycles", cyc, 32'd5);
    @(posedge clk); #1;
    check("basic_done_cnt", done_seen - d0, 32'd1);
    check("basic_q_empty", q.size(), 32'd0);
    check("basic_idle", {31'd0, busy}, 32'd0);

    // wrap-around
    d0 = done_seen;
    run_start(14, 4);
    wait_done(50, cyc);
    @(posedge clk); #1;
    check("wrap_done_cnt", done_seen - d0, 32'd1);
    check("wrap_q_empty", q.size(), 32'd0);

    // backpressure
    ready_mode = 0; ready_val = 1'b0;
    run_start(3, 4);
    wait_valid(20);
    for (int i = 0; i < 3; i++) begin
      check("stall_data", {24'd0, out_data}, 32'h13);
      check("stall_index", {28'd0, out_index}, 32'd3);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    ready_val = 1'b1;
    a0 = acc_cnt;
    wait_done(50, cyc);
    @(posedge clk); #1;
    check("stall_beats", acc_cnt - a0, 32'd4);
    check("stall_q_empty", q.size(), 32'd0);

    // count = 0
    ready_mode = 1;
    d0 = done_seen;
    run_start(5, 0);
    @(negedge clk);
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check("zero_done_cnt", done_seen - d0, 32'd1);

    // abort and start together in IDLE: start ignored
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; count = 5'd5; first_reg = 4'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", {31'd0, busy}, 32'd0);

    // full sweep with abort after the 5th accept
    d0 = done_seen;
    a0 = acc_cnt;
    run_start(0, 16);
    cyc = 0;
    while (acc_cnt - a0 < 5 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reach5", acc_cnt - a0, 32'd5);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    q.delete();
    model_run = 1'b0;
    @(negedge clk);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_last", {31'd0, out_last}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_seen - d0, 32'd0);
    run_start(9, 3);
    wait_done(50, cyc);
    @(posedge clk); #1;
    check("after_abort_done", done_seen - d0, 32'd1);
    check("after_abort_q", q.size(), 32'd0);

    // reset mid-run while a beat is held
    ready_mode = 0; ready_val = 1'b0;
    d0 = done_seen;
    run_start(2, 5);
    wait_valid(20);
    #2 reset = 1'b1;
    #1;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_last", {31'd0, out_last}, 32'd0);
    check("mrst_data", {24'd0, out_data}, 32'd0);
    check("mrst_index", {28'd0, out_index}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_rnum", {28'd0, reg_from_number}, 32'd0);
    q.delete();
    model_run = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_no_done", done_seen - d0, 32'd0);

    // randomized runs
    for (int t = 0; t < 40; t++) begin
      int f, c;
      for (int i = 0; i < N; i++) rf[i] = 8'($urandom);
      f = $urandom_range(0, N - 1);
      c = ($urandom % 8 == 0) ? 0 : $urandom_range(1, N);
      ready_mode = ($urandom % 2) ? 1 : 2;
      d0 = done_seen;
      run_start(f, c);
      if (c >= 8) begin
        // a start while running must be ignored
        @(posedge clk); #1;
        start = 1'b1;
        first_reg = 4'($urandom);
        count = 5'($urandom_range(0, N));
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_done(200, cyc);
      @(posedge clk); #1;
      check("rand_done_cnt", done_seen - d0, 32'd1);
      check("rand_q_empty", q.size(), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_stream_reader.md
Name: reg_stream_reader

Overview:
- Sequential read-out engine for the register file. It walks a contiguous, wrapping range of register indices and streams each value out over a valid/ready handshake.
- It drives the register file's read-index port and samples the read-data port combinationally. It never writes the register file.
- Used for debug dumps, context save to data memory, and bench register-file checking.

Parameters:
- W, 8, register data width (matches the register file).
- D, 4, register index width; the register file holds 2**D registers.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a read-out; sampled only in IDLE.
- first_reg  input  D  index of the first register to read; sampled with start.
- count  input  D+1  number of registers to read, 0..2**D; sampled with start.
- abort  input  1  cancels an in-progress read-out.
- reg_from_number  output  D  read index to the register file.
- reg_out  input  W  register file read data, combinational from reg_from_number.
- out_data  output  W  streamed register value.
- out_index  output  D  index the out_data value came from.
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_ready  input  1  consumer accepts the beat when high together with out_valid.
- out_last  output  1  marks the final beat of the read-out.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, immediate): state IDLE; addr=0; remaining=0.
- Reset outputs: out_valid=0, out_last=0, out_data=0, out_index=0, done=0, busy=0, reg_from_number=0.
- reg_from_number is always addr (a registered value).
- States: IDLE and RUN.
- IDLE, start=1 and count>0: next edge latches addr=first_reg and remaining=count, then enters RUN.
- IDLE, start=1 and count=0: no beats; done pulses on the next cycle; stays IDLE.
- IDLE, start=0: hold.
- RUN, load condition: remaining>0 and (out_valid=0 or out_ready=1). On a load edge:
  - out_data <= reg_out; out_index <= addr; out_valid <= 1.
  - out_last <= (remaining==1).
  - addr <= addr+1, modulo 2**D (wraps 2**D-1 -> 0).
  - remaining <= remaining-1.
- RUN, accept (out_valid & out_ready) with remaining=0: out_valid <= 0. If the accepted beat has out_last=1, then done <= 1 for one cycle and the state returns to IDLE.
- Throughput: one beat per cycle while out_ready stays high.
- Latency: first out_valid appears 2 cycles after the start edge (latch cycle, then load cycle).
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable. addr and remaining do not advance.
- count=2**D reads every register exactly once, starting at first_reg.
- abort in RUN: next edge clears out_valid and out_last, enters IDLE, and produces no done pulse. Any pending beat is dropped. abort in IDLE is a no-op.
- abort and start together in IDLE: abort wins; start is ignored.
- start while in RUN: ignored.
- Concurrent register-file writes: the captured value is the register contents at the load edge, before any write landing on that same edge.
- reset asserted mid-run: all state and outputs clear immediately; no done pulse.

Test Plan:
- Preload regs 0..15 with 0x10+i; start, first_reg=3, count=4, out_ready=1 -> beats (3,0x13),(4,0x14),(5,0x15),(6,0x16) on consecutive cycles; out_last only on index 6; done one cycle after the last accept.
- first_reg=14, count=4 -> indices 14,15,0,1 with data 0x1E,0x1F,0x10,0x11 (wrap).
- count=4; hold out_ready=0 for 3 cycles after the first valid, then 1 -> out_data stays 0x13 while stalled; no duplicated or skipped indices; 4 beats total.
- count=0 -> no out_valid; done pulses exactly once; busy stays 0.
- count=16, first_reg=0 -> 16 beats, indices 0..15; abort after the 5th accept -> out_valid=0 next cycle; no done; IDLE; the next start works normally.
- Assert reset mid-run with out_valid=1 -> all outputs read 0 before the next clock edge; no done.
